// File: rtl/memory_responder.sv
// ============================================================================
//  Module      : memory_responder
//  Description : Single-port 32-bit word memory with a fixed number of wait
//                states before every read/write response.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    input  logic              read,
    input  logic              write,
    output logic [31:0]       data_out,
    output logic              mem_ready,
    output logic              busy,
    output logic              req_err
);

    localparam int         C_DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic              r_is_write;
    logic [31:0]       r_mem [0:C_DEPTH-1];

    logic              w_accept;
    logic              w_conflict;
    logic              w_enter_respond;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [31:0]       w_acc_data;
    logic              w_acc_write;

    assign w_accept   = (r_state == ST_IDLE) && (read ^ write);
    assign w_conflict = (r_state == ST_IDLE) && read && write;

    // With zero wait states the access commits on the accepting edge itself,
    // so the live request is used instead of the not-yet-latched copy.
    assign w_acc_addr  = (r_state == ST_IDLE) ? addr    : r_addr;
    assign w_acc_data  = (r_state == ST_IDLE) ? data_in : r_data;
    assign w_acc_write = (r_state == ST_IDLE) ? write   : r_is_write;

    assign w_enter_respond = (w_next_state == ST_RESPOND) && (r_state != ST_RESPOND);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_RESPOND;
                end
            end
            ST_WAIT: begin
                if (r_count == 4'd1) begin
                    w_next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state    <= ST_IDLE;
            r_count    <= 4'd0;
            r_addr     <= '0;
            r_data     <= 32'd0;
            r_is_write <= 1'b0;
            data_out   <= 32'd0;
            mem_ready  <= 1'b0;
            busy       <= 1'b0;
            req_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_count    <= C_WAIT_LOAD;
                r_addr     <= addr;
                r_data     <= data_in;
                r_is_write <= write;
            end else if (r_state == ST_WAIT) begin
                r_count <= r_count - 4'd1;
            end
            if (w_enter_respond && !w_acc_write) begin
                data_out <= r_mem[w_acc_addr];
            end
            // Status flags trail the state by one edge so the ready pulse
            // lands in the cycle after RESPOND and busy covers it.
            mem_ready <= (r_state == ST_RESPOND);
            busy      <= (r_state == ST_WAIT) || (r_state == ST_RESPOND);
            req_err   <= w_conflict;
        end
    end

    // Memory array is deliberately left out of the reset domain.
    always_ff @(posedge clock) begin
        if (!clear && w_enter_respond && w_acc_write) begin
            r_mem[w_acc_addr] <= w_acc_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// ============================================================================
//  Module      : tb_memory_responder
//  Description : Directed self-checking bench for memory_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_responder;

    logic        clk = 1'b0;
    logic        clear = 1'b1;

    logic [8:0]  addr0 = '0;
    logic [31:0] data0 = '0;
    logic        read0 = 1'b0, write0 = 1'b0;
    logic [31:0] dout0;
    logic        ready0, busy0, err0;

    logic [8:0]  addr1 = '0;
    logic [31:0] data1 = '0;
    logic        read1 = 1'b0, write1 = 1'b0;
    logic [31:0] dout1;
    logic        ready1, busy1, err1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_responder #(.ADDR_W(9), .WAIT_STATES(2)) u_dut_w2 (
        .clock(clk), .clear(clear), .addr(addr0), .data_in(data0),
        .read(read0), .write(write0), .data_out(dout0),
        .mem_ready(ready0), .busy(busy0), .req_err(err0)
    );

    memory_responder #(.ADDR_W(9), .WAIT_STATES(0)) u_dut_w0 (
        .clock(clk), .clear(clear), .addr(addr1), .data_in(data1),
        .read(read1), .write(write1), .data_out(dout1),
        .mem_ready(ready1), .busy(busy1), .req_err(err1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full requester handshake on the WAIT_STATES=2 instance.
    task automatic access(input bit wr, input logic [8:0] a, input logic [31:0] d,
                          input string tag, output logic [31:0] rdata);
        int cycles;
        int busy_cnt;
        read0  = !wr;
        write0 = wr;
        addr0  = a;
        data0  = d;
        tick();
        cycles   = 1;
        busy_cnt = 0;
        while (!ready0 && cycles < 20) begin
            busy_cnt += int'(busy0);
            tick();
            cycles++;
        end
        busy_cnt += int'(busy0);
        read0  = 1'b0;
        write0 = 1'b0;
        check_val({tag, "_latency"}, 32'(cycles), 32'd4);
        check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd3);
        rdata = dout0;
        tick();
        check_val({tag, "_ready_one_shot"}, 32'(ready0), 32'd0);
        check_val({tag, "_busy_clear"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int pulses;

        tick();
        tick();
        clear = 1'b0;
        check_val("rst_data_out", dout0, 32'd0);
        check_val("rst_ready", 32'(ready0), 32'd0);
        check_val("rst_busy", 32'(busy0), 32'd0);
        check_val("rst_err", 32'(err0), 32'd0);
        check_val("rst_data_out_w0", dout1, 32'd0);

        access(1'b1, 9'd5, 32'hDEADBEEF, "wr5", rd);
        access(1'b0, 9'd5, 32'h0, "rd5", rd);
        check_val("rd5_data", rd, 32'hDEADBEEF);

        access(1'b1, 9'd0, 32'h12345678, "wr0", rd);
        access(1'b1, 9'd511, 32'hCAFEBABE, "wr511", rd);
        access(1'b0, 9'd0, 32'h0, "rd0", rd);
        check_val("rd0_data", rd, 32'h12345678);
        access(1'b0, 9'd511, 32'h0, "rd511", rd);
        check_val("rd511_data", rd, 32'hCAFEBABE);

        // Conflicting request
        access(1'b1, 9'd3, 32'h33333333, "wr3", rd);
        check_val("write_keeps_data_out", dout0, 32'hCAFEBABE);
        read0 = 1'b1; write0 = 1'b1; addr0 = 9'd3; data0 = 32'h0BADF00D;
        tick();
        read0 = 1'b0; write0 = 1'b0;
        check_val("conflict_err", 32'(err0), 32'd1);
        check_val("conflict_ready", 32'(ready0), 32'd0);
        check_val("conflict_busy", 32'(busy0), 32'd0);
        tick();
        check_val("conflict_err_one_shot", 32'(err0), 32'd0);
        check_val("conflict_keeps_data_out", dout0, 32'hCAFEBABE);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            pulses += int'(ready0) + int'(busy0);
            tick();
        end
        check_val("conflict_no_activity", 32'(pulses), 32'd0);
        access(1'b0, 9'd3, 32'h0, "rd3", rd);
        check_val("rd3_data", rd, 32'h33333333);

        // Clear aborts an in-flight write
        access(1'b1, 9'd7, 32'h77777777, "wr7", rd);
        write0 = 1'b1; addr0 = 9'd7; data0 = 32'hFACECAFE;
        tick();
        write0 = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_val("abort_data_out", dout0, 32'd0);
        check_val("abort_ready", 32'(ready0), 32'd0);
        check_val("abort_busy", 32'(busy0), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pulses += int'(ready0);
            tick();
        end
        check_val("abort_no_ready", 32'(pulses), 32'd0);
        access(1'b0, 9'd7, 32'h0, "rd7", rd);
        check_val("rd7_data", rd, 32'h77777777);

        // Requests during WAIT/RESPOND are ignored
        access(1'b1, 9'd9, 32'h09090909, "wr9", rd);
        read0 = 1'b1; write0 = 1'b0; addr0 = 9'd5;
        tick();
        pulses = int'(ready0);
        read0 = 1'b0; write0 = 1'b1; addr0 = 9'd9; data0 = 32'h99999999;
        tick();
        pulses += int'(ready0);
        read0 = 1'b1; write0 = 1'b0; addr0 = 9'd9;
        tick();
        pulses += int'(ready0);
        read0 = 1'b1; write0 = 1'b1;
        tick();
        read0 = 1'b0; write0 = 1'b0;
        check_val("ignore_ready_at_4", 32'(ready0), 32'd1);
        check_val("ignore_data", dout0, 32'hDEADBEEF);
        for (int i = 0; i < 6; i++) begin
            pulses += int'(ready0);
            tick();
        end
        check_val("ignore_single_pulse", 32'(pulses), 32'd1);
        access(1'b0, 9'd9, 32'h0, "rd9", rd);
        check_val("rd9_data", rd, 32'h09090909);

        // Zero wait states, read held continuously
        write1 = 1'b1; addr1 = 9'd2; data1 = 32'h22222222;
        tick();
        write1 = 1'b0;
        tick();
        check_val("w0_write_ready", 32'(ready1), 32'd1);
        read1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_val($sformatf("w0_ready_k%0d", k), 32'(ready1), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_val($sformatf("w0_data_k%0d", k), dout1, 32'h22222222);
        end
        read1 = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_W, default 9, word-address width; memory depth SHALL be 2**ADDR_W 32-bit words.
REQ-002 Parameter WAIT_STATES, default 2, legal range 0..15, number of idle wait cycles inserted before each response.
REQ-003 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 addr  input  ADDR_W  word address of the request, driven from MAR.
REQ-006 data_in  input  32  write data, driven from MDR.
REQ-007 read  input  1  read request, level.
REQ-008 write  input  1  write request, level.
REQ-009 data_out  output  32  read data returned to MDR; registered.
REQ-010 mem_ready  output  1  one-cycle completion pulse for an accepted request; registered.
REQ-011 busy  output  1  high while a request is in flight, i.e. in WAIT or RESPOND; registered.
REQ-012 req_err  output  1  one-cycle pulse when read and write are both sampled high in IDLE; registered.

Function
REQ-013 FSM states: IDLE, WAIT, RESPOND.
REQ-014 Requests are sampled only in IDLE; read/write in WAIT or RESPOND SHALL be ignored.
REQ-015 IDLE, exactly one of read/write high at edge N: latch addr, data_in and op; load wait counter with WAIT_STATES.
- Next state: WAIT if WAIT_STATES>0, else RESPOND.
REQ-016 WAIT: counter decrements each edge; transition to RESPOND on the edge where counter==1.
REQ-017 Latency: mem_ready SHALL be high in exactly the cycle following edge N+1+WAIT_STATES, for one cycle only.
REQ-018 Write commit: on the edge entering RESPOND, mem[latched addr] <= latched data.
REQ-019 Read: on the edge entering RESPOND, data_out <= mem[latched addr].
REQ-020 data_out SHALL hold its value until the next read completes; writes and errors SHALL NOT change it.
REQ-021 RESPOND always returns to IDLE on the next edge.
- A request still high in that IDLE cycle is a new request.
- The requester drops read/write during the mem_ready cycle.
REQ-022 Back-to-back throughput: one access per WAIT_STATES+2 cycles.
REQ-023 Read-after-write to the same address SHALL return the newly written data.
REQ-024 read and write both high in IDLE: no access, state stays IDLE, req_err pulses one cycle, mem_ready stays low.
REQ-025 Address wrap: none required, because ADDR_W spans the full depth; every addr value is legal.
REQ-026 busy SHALL be high from the edge after acceptance through the mem_ready cycle inclusive.

Reset
REQ-027 clear sampled high at any edge: state<=IDLE, counter<=0, data_out<=0, mem_ready<=0, busy<=0, req_err<=0.
REQ-028 clear mid-operation SHALL abort the in-flight request: no write commit, no mem_ready pulse.
REQ-029 clear SHALL NOT initialise memory contents.
REQ-030 clear has priority over any request sampled on the same edge.

Verification
REQ-031 WAIT_STATES=2: write 0xDEADBEEF to addr 5, then read addr 5.
- mem_ready rises 4 cycles after each request edge.
- data_out=0xDEADBEEF; busy high for exactly 3 cycles per access.
REQ-032 Write 0x12345678 to addr 0 and 0xCAFEBABE to addr 511, then read both.
- Reads return 0x12345678 and 0xCAFEBABE in order.
REQ-033 read=write=1 at addr 3 in IDLE.
- req_err pulses once; mem_ready=0; busy=0.
- A subsequent read of addr 3 returns the prior contents.
REQ-034 Write 0xFACECAFE to addr 7; assert clear during WAIT; then read addr 7.
- No mem_ready pulse for the aborted write.
- The read returns the pre-write contents; data_out=0 immediately after clear.
REQ-035 Issue a read; toggle read/write with a different addr during WAIT.
- Ignored: only the original access completes, with one mem_ready pulse.
REQ-036 WAIT_STATES=0: read held high continuously on addr 2.
- mem_ready pulses every 2nd cycle; data_out is stable between pulses.
